// File: rtl/product_bcd_converter.sv
// Sequential double-dabble binary-to-BCD converter, one bit per clock, with a start/busy/done handshake.
// Optional registered leading-zero blank flags when BCD_LEADING_ZERO_BLANK_EN is defined.
module product_bcd_converter #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
`ifdef BCD_LEADING_ZERO_BLANK_EN
  ,
  output logic [DIGITS-1:0]     blank
`endif
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [BW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [BW-1:0]    bcd_q, bcd_d;
  logic [BW-1:0]    adj;
  logic [BW-1:0]    acc_sh;
  logic [WIDTH-1:0] sr_sh;
`ifdef BCD_LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] blank_q, blank_d, blank_nx;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
`ifdef BCD_LEADING_ZERO_BLANK_EN
      blank_q <= {{(DIGITS-1){1'b1}}, 1'b0};
`endif
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
`ifdef BCD_LEADING_ZERO_BLANK_EN
      blank_q <= blank_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;

    // Add-3 correction per digit, no inter-digit carry, then a joint left shift.
    adj = acc_q;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (acc_q[4*d +: 4] >= 4'd5) adj[4*d +: 4] = acc_q[4*d +: 4] + 4'd3;
    end
    {acc_sh, sr_sh} = {adj, sr_q} << 1;

`ifdef BCD_LEADING_ZERO_BLANK_EN
    blank_d  = blank_q;
    blank_nx = '0;
    for (int unsigned k = 1; k < DIGITS; k++) begin
      blank_nx[k] = 1'b1;
      for (int unsigned j = k; j < DIGITS; j++) begin
        if (acc_sh[4*j +: 4] != 4'd0) blank_nx[k] = 1'b0;
      end
    end
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          sr_d    = bin;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        acc_d = acc_sh;
        sr_d  = sr_sh;
        if (cnt_q == LAST) begin
          bcd_d   = acc_sh;
`ifdef BCD_LEADING_ZERO_BLANK_EN
          blank_d = blank_nx;
`endif
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);
  assign bcd  = bcd_q;
`ifdef BCD_LEADING_ZERO_BLANK_EN
  assign blank = blank_q;
`endif

endmodule

// File: tb/tb_product_bcd_converter.sv
// Self-checking bench for product_bcd_converter against an arithmetic (divide/modulo) reference model.
module tb_product_bcd_converter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  bin = '0;
  logic        busy, done;
  logic [11:0] bcd;
`ifdef BCD_LEADING_ZERO_BLANK_EN
  logic [2:0]  blank;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  product_bcd_converter #(.WIDTH(8), .DIGITS(3)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd)
`ifdef BCD_LEADING_ZERO_BLANK_EN
    ,
    .blank (blank)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] ref_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [2:0] ref_blank(input int v);
    return {v < 100, v < 10, 1'b0};
  endfunction

  // Launch a conversion, count cycles to done, check result, busy and pulse width.
  task automatic convert(input logic [7:0] v, input string tag);
    int cyc;
    @(negedge clk);
    bin = v; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 20) begin
      n_cmp++;
      if (busy !== 1'b1) begin
        n_bad++;
        $display("FAIL %s busy_during: got %b expected 1 (cycle %0d)", tag, busy, cyc);
      end
      @(posedge clk); #1;
      cyc++;
    end
    n_cmp++;
    if (cyc !== 8) begin
      n_bad++;
      $display("FAIL %s latency: got %0d cycles expected 8", tag, cyc);
    end
    n_cmp++;
    if (bcd !== ref_bcd(int'(v))) begin
      n_bad++;
      $display("FAIL %s bcd: bin=%0d got %h expected %h", tag, v, bcd, ref_bcd(int'(v)));
    end
`ifdef BCD_LEADING_ZERO_BLANK_EN
    n_cmp++;
    if (blank !== ref_blank(int'(v))) begin
      n_bad++;
      $display("FAIL %s blank: bin=%0d got %b expected %b", tag, v, blank, ref_blank(int'(v)));
    end
`endif
    @(posedge clk); #1;
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s after_done: got done=%b busy=%b expected 0 0", tag, done, busy);
    end
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || bcd !== 12'h000) begin
      n_bad++;
      $display("FAIL reset_state: got busy=%b done=%b bcd=%h expected 0 0 000", busy, done, bcd);
    end
`ifdef BCD_LEADING_ZERO_BLANK_EN
    n_cmp++;
    if (blank !== 3'b110) begin
      n_bad++;
      $display("FAIL reset_blank: got %b expected 110", blank);
    end
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_corners();
    convert(8'd0, "zero");
    convert(8'd225, "max_product");
  endtask

  task automatic test_back_to_back();
    int t1, t2, cyc;
    logic [11:0] exp_b;
    @(negedge clk);
    bin = 8'd255; start = 1'b1;
    @(posedge clk);
    #1 bin = 8'd9;
    cyc = 0; t1 = -1; t2 = -1;
    while (t2 < 0 && cyc < 40) begin
      if (done === 1'b1) begin
        exp_b = (t1 < 0) ? ref_bcd(255) : ref_bcd(9);
        n_cmp++;
        if (bcd !== exp_b) begin
          n_bad++;
          $display("FAIL b2b_bcd: got %h expected %h", bcd, exp_b);
        end
        if (t1 < 0) t1 = cyc; else begin t2 = cyc; start = 1'b0; end
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    n_cmp++;
    if (t1 < 0 || t2 < 0 || t2 - t1 != 10) begin
      n_bad++;
      $display("FAIL b2b_spacing: got t1=%0d t2=%0d expected spacing 10", t1, t2);
    end
`ifdef BCD_LEADING_ZERO_BLANK_EN
    n_cmp++;
    if (blank !== 3'b110) begin
      n_bad++;
      $display("FAIL b2b_blank: got %b expected 110", blank);
    end
`endif
    repeat (3) @(posedge clk);
  endtask

  task automatic test_ignore_start();
    int cyc;
    @(negedge clk);
    bin = 8'd100; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 bin = 8'd42; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    n_cmp++;
    if (bcd !== 12'h100) begin
      n_bad++;
      $display("FAIL ignore_bcd: got %h expected 100", bcd);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL ignore_busy_fall: got %b expected 0", busy);
    end
    repeat (12) @(posedge clk);
    #1;
    n_cmp++;
    if (busy !== 1'b0 || bcd !== 12'h100) begin
      n_bad++;
      $display("FAIL ignore_no_queue: got busy=%b bcd=%h expected 0 100", busy, bcd);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bin = 8'd199; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || bcd !== 12'h000) begin
      n_bad++;
      $display("FAIL midreset: got busy=%b done=%b bcd=%h expected 0 0 000", busy, done, bcd);
    end
    @(negedge clk);
    rst = 1'b0;
    convert(8'd10, "after_reset");
  endtask

  task automatic test_sweep();
    for (int v = 0; v < 256; v++) convert(8'(v), "sweep");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      convert(8'($urandom_range(0, 255)), "random");
    end
  endtask

  initial begin
    test_reset();
    test_corners();
    test_back_to_back();
    test_ignore_start();
    test_reset_mid();
    test_sweep();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
